// File: rtl/capsense_scan_controller.sv
// Capacitive pad scan sequencer: discharge, charge, time each pad's rise, publish per-pad counts.
// Optional readings low-pass filter enabled by defining CAPSENSE_FILTER_EN.
module capsense_scan_controller #(
    parameter int NUM_PADS         = 9,
    parameter int CNT_W            = 32,
    parameter int DISCHARGE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NUM_PADS-1:0]       i_sense_in,
    output logic                      o_drive_out,
    output logic [NUM_PADS*CNT_W-1:0] o_readings,
    output logic                      o_scan_done,
    output logic                      o_scan_busy,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISCHARGE = 2'd1,
        ST_CHARGE    = 2'd2,
        ST_LATCH     = 2'd3
    } state_t;

    localparam int                DCNT_W      = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [NUM_PADS-1:0]         r_sync1;
    logic [NUM_PADS-1:0]         r_sync2;
    logic [DCNT_W-1:0]           r_dcnt;
    logic [CNT_W-1:0]            r_timer;
    logic [CNT_W-1:0]            r_cap [NUM_PADS];
    logic [CNT_W-1:0]            w_cap_next [NUM_PADS];
    logic [NUM_PADS-1:0]         r_valid;
    logic [NUM_PADS-1:0]         w_valid_next;
    logic                        w_commit;
    logic [NUM_PADS*CNT_W-1:0]   r_readings;
    logic [NUM_PADS*CNT_W-1:0]   w_readings_next;
    logic                        r_scan_done;

    // Captures that land this cycle are folded in before the all-valid and timeout decisions.
    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_commit     = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) begin
            w_cap_next[i] = r_cap[i];
        end
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_next = ST_DISCHARGE;
            end
            ST_DISCHARGE: begin
                if (!i_enable)                w_state_next = ST_IDLE;
                else if (r_dcnt == DCNT_LAST) w_state_next = ST_CHARGE;
            end
            ST_CHARGE: begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    if (r_sync2[i] && !r_valid[i]) begin
                        w_cap_next[i]   = r_timer;
                        w_valid_next[i] = 1'b1;
                    end
                end
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end else if (&w_valid_next) begin
                    w_state_next = ST_LATCH;
                    w_commit     = 1'b1;
                end else if (r_timer == TIMEOUT_VAL) begin
                    for (int i = 0; i < NUM_PADS; i++) begin
                        if (!w_valid_next[i]) w_cap_next[i] = TIMEOUT_VAL;
                    end
                    w_state_next = ST_LATCH;
                    w_commit     = 1'b1;
                end
            end
            ST_LATCH: begin
                w_state_next = i_enable ? ST_DISCHARGE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef CAPSENSE_FILTER_EN
    logic [NUM_PADS-1:0] r_seeded;

    // Seeded flags survive aborts; only reset forces the next latch to reload raw counts.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)      r_seeded <= '0;
        else if (w_commit) r_seeded <= '1;
    end

    always_comb begin
        w_readings_next = r_readings;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (r_seeded[i]) begin
                w_readings_next[i*CNT_W +: CNT_W] = r_readings[i*CNT_W +: CNT_W]
                                                  - (r_readings[i*CNT_W +: CNT_W] >> 2)
                                                  + (w_cap_next[i] >> 2);
            end else begin
                w_readings_next[i*CNT_W +: CNT_W] = w_cap_next[i];
            end
        end
    end
`else
    always_comb begin
        w_readings_next = r_readings;
        for (int i = 0; i < NUM_PADS; i++) begin
            w_readings_next[i*CNT_W +: CNT_W] = w_cap_next[i];
        end
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_dcnt      <= '0;
            r_timer     <= '0;
            r_valid     <= '0;
            r_readings  <= '0;
            r_scan_done <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) begin
                r_cap[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_sync1     <= i_sense_in;
            r_sync2     <= r_sync1;
            r_scan_done <= w_commit;
            r_dcnt      <= (r_state == ST_DISCHARGE) ? r_dcnt + 1'b1 : '0;
            r_valid     <= (r_state == ST_CHARGE) ? w_valid_next : '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                r_cap[i] <= w_cap_next[i];
            end
            // Timer holds 1 outside CHARGE so the first charge cycle reads 1; saturates at timeout.
            if (r_state != ST_CHARGE)       r_timer <= CNT_W'(1);
            else if (r_timer != TIMEOUT_VAL) r_timer <= r_timer + 1'b1;
            if (w_commit) r_readings <= w_readings_next;
        end
    end

    // Drive drops the moment enable falls, without waiting for the abort edge.
    assign o_drive_out = (r_state == ST_CHARGE) && i_enable;
    assign o_readings  = r_readings;
    assign o_scan_done = r_scan_done;
    assign o_scan_busy = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_capsense_scan_controller.sv
// Directed bench for capsense_scan_controller: table of scan vectors plus abort and reset sequences.
// Models the CAPSENSE_FILTER_EN readings filter when that macro is defined.
module tb_capsense_scan_controller;

    localparam int NUM_PADS = 9;
    localparam int CNT_W    = 32;
    localparam int DIS      = 4;
    localparam int TMO      = 100;
    localparam int NEVER    = 1000;

    logic                      clk;
    logic                      rst_n;
    logic                      enable;
    logic [NUM_PADS-1:0]       sense;
    logic                      o_drive_out;
    logic [NUM_PADS*CNT_W-1:0] o_readings;
    logic                      o_scan_done;
    logic                      o_scan_busy;
    logic [1:0]                o_dbg_state;

    capsense_scan_controller #(
        .NUM_PADS(NUM_PADS), .CNT_W(CNT_W), .DISCHARGE_CYCLES(DIS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_enable(enable), .i_sense_in(sense),
        .o_drive_out(o_drive_out), .o_readings(o_readings), .o_scan_done(o_scan_done),
        .o_scan_busy(o_scan_busy), .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rise: CHARGE cycle in which the raw pad goes high (0 = high before charge, NEVER = stays low).
    typedef struct {
        int rise [NUM_PADS];
        int cap  [NUM_PADS];
        int exp_k;
    } vec_t;

    vec_t        vt [8];
    logic [31:0] model  [NUM_PADS];
    bit          seeded [NUM_PADS];
    int          n_checks = 0;
    int          n_bad    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_readings(input string name);
        for (int i = 0; i < NUM_PADS; i++) begin
            check($sformatf("%s[%0d]", name, i), o_readings[i*CNT_W +: CNT_W], model[i]);
        end
    endtask

    task automatic model_latch(input int idx);
        for (int i = 0; i < NUM_PADS; i++) begin
`ifdef CAPSENSE_FILTER_EN
            if (seeded[i]) model[i] = model[i] - (model[i] >> 2) + (32'(vt[idx].cap[i]) >> 2);
            else           model[i] = 32'(vt[idx].cap[i]);
            seeded[i] = 1'b1;
`else
            model[i] = 32'(vt[idx].cap[i]);
`endif
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_PADS; i++) begin
            model[i]  = '0;
            seeded[i] = 1'b0;
        end
    endtask

    // mode 0: run to completion; 1: drop enable at charge cycle at_k; 2: assert reset at at_k.
    task automatic do_scan(input int idx, input int mode, input int at_k);
        int lo;
        int k;
        bit done_seen;
        lo = 0;
        done_seen = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) if (vt[idx].rise[i] == 0) sense[i] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (o_drive_out) break;
            if (o_scan_busy && !o_scan_done) lo++;
        end
        check("discharge_len", lo, DIS);
        check("charge_start", {31'd0, o_drive_out}, 1);
        if (!o_drive_out) return;
        k = 1;
        while (k <= TMO + 5) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (vt[idx].rise[i] >= 1 && k >= vt[idx].rise[i]) sense[i] = 1'b1;
            end
            if (mode == 1 && k == at_k) begin
                enable = 1'b0;
                #1;
                check("abort_drive_now", {31'd0, o_drive_out}, 0);
                @(negedge clk);
                check("abort_state", {30'd0, o_dbg_state}, 0);
                check("abort_busy", {31'd0, o_scan_busy}, 0);
                check("abort_done", {31'd0, o_scan_done}, 0);
                check_readings("abort_readings");
                sense = '0;
                return;
            end
            if (mode == 2 && k == at_k) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rst_drive", {31'd0, o_drive_out}, 0);
                check("rst_busy", {31'd0, o_scan_busy}, 0);
                check("rst_done", {31'd0, o_scan_done}, 0);
                check_readings("rst_readings");
                sense = '0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (o_scan_done) begin
                done_seen = 1'b1;
                break;
            end
            k++;
            check("charge_drive", {31'd0, o_drive_out}, 1);
            if (!o_drive_out) break;
        end
        check("scan_done_seen", {31'd0, done_seen}, 1);
        if (!done_seen) return;
        check("charge_len", k, vt[idx].exp_k);
        check("latch_drive", {31'd0, o_drive_out}, 0);
        check("latch_busy", {31'd0, o_scan_busy}, 1);
        model_latch(idx);
        check_readings("readings");
        sense = '0;
    endtask

    // Continuous properties: no back-to-back done, readings move only with done.
    logic                      prev_done = 1'b0;
    logic                      prev_rst  = 1'b0;
    logic [NUM_PADS*CNT_W-1:0] prev_rd   = '0;
    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            check("done_twice", {31'd0, o_scan_done && prev_done}, 0);
            check("readings_stable", {31'd0, (o_readings != prev_rd) && !o_scan_done}, 0);
        end
        prev_done = o_scan_done;
        prev_rst  = rst_n;
        prev_rd   = o_readings;
    end

    initial begin
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                vt[v].rise[i] = 0;
                vt[v].cap[i]  = 0;
            end
        end
        for (int i = 0; i < NUM_PADS; i++) begin
            vt[0].rise[i] = 10 * (i + 1);  vt[0].cap[i] = 10 * (i + 1) + 2;
            vt[1].rise[i] = (i < 8) ? 5 : NEVER; vt[1].cap[i] = (i < 8) ? 7 : 100;
            vt[2].rise[i] = 0;             vt[2].cap[i] = 1;
            vt[3].rise[i] = 1;             vt[3].cap[i] = 3;
            vt[4].rise[i] = 3 * (i + 1);   vt[4].cap[i] = 3 * (i + 1) + 2;
            vt[5].rise[i] = 9 - i;         vt[5].cap[i] = 11 - i;
            vt[6].rise[i] = 38;            vt[6].cap[i] = 40;
            vt[7].rise[i] = 78;            vt[7].cap[i] = 80;
        end
        vt[3].rise[0] = 98; vt[3].cap[0] = 100;
        vt[3].rise[1] = 99; vt[3].cap[1] = 100;
        vt[0].exp_k = 92; vt[1].exp_k = 100; vt[2].exp_k = 1; vt[3].exp_k = 100;
        vt[4].exp_k = 29; vt[5].exp_k = 11;  vt[6].exp_k = 40; vt[7].exp_k = 80;
        model_reset();

        rst_n  = 1'b0;
        enable = 1'b0;
        sense  = '0;
        #23;
        check("reset_drive", {31'd0, o_drive_out}, 0);
        check("reset_busy", {31'd0, o_scan_busy}, 0);
        check_readings("reset_readings");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_drive", {31'd0, o_drive_out}, 0);
            check("idle_busy", {31'd0, o_scan_busy}, 0);
            check("idle_done", {31'd0, o_scan_done}, 0);
        end
        check_readings("idle_readings");

        enable = 1'b1;
        for (int v = 0; v < 5; v++) do_scan(v, 0, 0);

        // Abort during charge: readings keep scan vt[4] result.
        do_scan(6, 1, 30);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_abort_done", {31'd0, o_scan_done}, 0);
            check("post_abort_busy", {31'd0, o_scan_busy}, 0);
        end
        check_readings("post_abort_readings");
        enable = 1'b1;
        do_scan(5, 0, 0);

        do_scan(6, 2, 20);
        do_scan(6, 0, 0);
        do_scan(7, 0, 0);

        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("final_busy", {31'd0, o_scan_busy}, 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
